// File: rtl/noc_input_unit_pkg.sv
// Shared codes for the NoC input unit: allocator destination codes and
// input-unit FSM state encoding.
package noc_input_unit_pkg;

  localparam logic [2:0] EMPTY          = 3'd0;
  localparam logic [2:0] OUT_LOCAL_PORT = 3'd1;
  localparam logic [2:0] OUT_X1_PORT    = 3'd2;
  localparam logic [2:0] OUT_X2_PORT    = 3'd3;
  localparam logic [2:0] OUT_Y1_PORT    = 3'd4;

  typedef enum logic [1:0] {
    IN_IDLE = 2'd0,
    IN_REQ  = 2'd1,
    IN_GAP  = 2'd2
  } in_state_e;

endpackage

// File: rtl/noc_flit_fifo.sv
// DEPTH x FLIT_W synchronous FIFO. Pushes while full and pops while empty
// are ignored; a simultaneous push and pop leaves the count unchanged.
module noc_flit_fifo #(
  parameter int FLIT_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [FLIT_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [FLIT_W-1:0] head_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [FLIT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push_en;
  logic              pop_en;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign push_en = push_i & ~full_o;
  assign pop_en  = pop_i & ~empty_o;

  // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_en)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_en, pop_en})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset flushes all buffered flits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/noc_input_unit.sv
// Input side of one router port: buffers flits, computes the XY route of the
// FIFO head, requests the switch allocator and forwards the head on grant.
// Optional feature macro: IN_UNIT_CREDIT_EN adds the credit_out pulse port.
//
// state   | meaning
// IN_IDLE | FIFO empty (or just left GAP with nothing buffered), no request
// IN_REQ  | requesting route(head) from allocator, waiting for grant
// IN_GAP  | one-cycle quiet slot after a pop so a stale request is not re-granted
module noc_input_unit
  import noc_input_unit_pkg::*;
#(
  parameter int FLIT_W = 16,
  parameter int DEPTH  = 4,
  parameter int X_W    = 2,
  parameter int Y_W    = 1,
  parameter int CUR_X  = 0,
  parameter int CUR_Y  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [FLIT_W-1:0] in_flit,
  output logic              in_ready,
  output logic [2:0]        port_dst,
  input  logic              grant,
  output logic              out_valid,
  output logic [FLIT_W-1:0] out_flit
`ifdef IN_UNIT_CREDIT_EN
  ,
  output logic              credit_out
`endif
);

  localparam logic [X_W-1:0] CUR_X_L = X_W'(CUR_X);
  localparam logic [Y_W-1:0] CUR_Y_L = Y_W'(CUR_Y);

  in_state_e         state_q, state_d;
  logic [FLIT_W-1:0] head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic [2:0]        route;
  logic [X_W-1:0]    dst_x;
  logic [Y_W-1:0]    dst_y;
  logic              out_valid_q;
  logic [FLIT_W-1:0] out_flit_q;

  noc_flit_fifo #(
    .FLIT_W (FLIT_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (in_valid),
    .push_data_i (in_flit),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign in_ready = ~fifo_full;
  assign dst_x    = head[FLIT_W-1 -: X_W];
  assign dst_y    = head[FLIT_W-1-X_W -: Y_W];

  // XY routing on the FIFO head: resolve X first, then Y, else eject locally.
  always_comb begin
    route = OUT_LOCAL_PORT;
    if (dst_x < CUR_X_L)       route = OUT_X1_PORT;
    else if (dst_x > CUR_X_L)  route = OUT_X2_PORT;
    else if (dst_y != CUR_Y_L) route = OUT_Y1_PORT;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IN_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IN_IDLE: if (!fifo_empty) state_d = IN_REQ;
      IN_REQ:  if (grant)       state_d = IN_GAP;
      IN_GAP:  state_d = fifo_empty ? IN_IDLE : IN_REQ;
      default: state_d = IN_IDLE;
    endcase
  end

  // FSM outputs: request code to allocator and pop strobe (only in REQ).
  always_comb begin
    port_dst = EMPTY;
    pop      = 1'b0;
    if (state_q == IN_REQ) begin
      port_dst = route;
      pop      = grant;
    end
  end

  // Registered crossbar output: one-cycle valid pulse carrying the popped head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_flit_q  <= '0;
    end else begin
      out_valid_q <= pop;
      if (pop) out_flit_q <= head;
    end
  end

  assign out_valid = out_valid_q;
  assign out_flit  = out_flit_q;

`ifdef IN_UNIT_CREDIT_EN
  logic credit_q;

  // Credit return to upstream, coincident with out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) credit_q <= 1'b0;
    else        credit_q <= pop;
  end

  assign credit_out = credit_q;
`endif

endmodule

// File: tb/tb_noc_input_unit.sv
module tb_noc_input_unit;
  localparam int FLIT_W = 16;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic [FLIT_W-1:0] in_flit;
  logic              in_ready;
  logic [2:0]        port_dst;
  logic              grant;
  logic              out_valid;
  logic [FLIT_W-1:0] out_flit;
`ifdef IN_UNIT_CREDIT_EN
  logic              credit_out;
  int                n_ov;
  int                n_cr;
`endif

  int n_chk;
  int n_fail;

  noc_input_unit #(
    .FLIT_W (16),
    .DEPTH  (4),
    .X_W    (2),
    .Y_W    (1),
    .CUR_X  (1),
    .CUR_Y  (0)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_flit   (in_flit),
    .in_ready  (in_ready),
    .port_dst  (port_dst),
    .grant     (grant),
    .out_valid (out_valid),
    .out_flit  (out_flit)
`ifdef IN_UNIT_CREDIT_EN
    ,
    .credit_out(credit_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef IN_UNIT_CREDIT_EN
  always @(negedge clk) begin
    if (out_valid)  n_ov++;
    if (credit_out) n_cr++;
  end
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_flit  = '0;
    grant    = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic push(input logic [FLIT_W-1:0] f);
    in_valid = 1'b1;
    in_flit  = f;
    tick();
    in_valid = 1'b0;
  endtask

  // push one flit into an empty unit, check IDLE->REQ->grant->GAP->IDLE
  task automatic send_one(input string tag, input logic [FLIT_W-1:0] f, input logic [2:0] exp_dst);
    push(f);
    chk({tag, "_idle_dst"}, 32'(port_dst), 32'd0);
    tick();
    chk({tag, "_req_dst"}, 32'(port_dst), 32'(exp_dst));
    chk({tag, "_req_noval"}, 32'(out_valid), 32'd0);
    grant = 1'b1;
    tick();
    grant = 1'b0;
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_out_flit"}, 32'(out_flit), 32'(f));
    chk({tag, "_gap_dst"}, 32'(port_dst), 32'd0);
    tick();
    chk({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_idle_dst2"}, 32'(port_dst), 32'd0);
  endtask

  logic [FLIT_W-1:0] g [4];
  logic [2:0]        gr [4];
  logic [FLIT_W-1:0] h [5];

  initial begin
    n_chk  = 0;
    n_fail = 0;
`ifdef IN_UNIT_CREDIT_EN
    n_ov = 0;
    n_cr = 0;
`endif
    g[0] = 16'h0011; gr[0] = 3'd2;  // dst (0,0) -> X1
    g[1] = 16'hE022; gr[1] = 3'd3;  // dst (3,1) -> X2
    g[2] = 16'h6033; gr[2] = 3'd4;  // dst (1,1) -> Y1
    g[3] = 16'h4044; gr[3] = 3'd1;  // dst (1,0) -> LOCAL

    // reset state
    do_reset();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_port_dst", 32'(port_dst), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_flit", 32'(out_flit), 32'd0);
    chk("rst_count", 32'(u_dut.u_fifo.count_q), 32'd0);

    // route for each direction, single-flit handshake
    send_one("x1", 16'h00A1, 3'd2);
    send_one("x2", 16'hE0B2, 3'd3);
    send_one("y1", 16'h60C3, 3'd4);
    send_one("lo", 16'h40D4, 3'd1);

    // fill, hold grant low; extra pushes while full must be dropped
    do_reset();
    for (int i = 0; i < 4; i++) push(g[i]);
    chk("fill_in_ready", 32'(in_ready), 32'd0);
    chk("fill_count", 32'(u_dut.u_fifo.count_q), 32'd4);
    in_valid = 1'b1;
    in_flit  = 16'h0F0F;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_dst", 32'(port_dst), 32'(gr[0]));
      chk("hold_noval", 32'(out_valid), 32'd0);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;

    // grant held high: pops only from REQ, one flit per 2 cycles, in order
    grant = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i % 2 == 0) begin
        chk("drain_valid", 32'(out_valid), 32'd1);
        chk("drain_flit", 32'(out_flit), 32'(g[i/2]));
        chk("drain_gap_dst", 32'(port_dst), 32'd0);
      end else begin
        chk("drain_gap_noval", 32'(out_valid), 32'd0);
        chk("drain_req_dst", 32'(port_dst), (i < 7) ? 32'(gr[(i+1)/2]) : 32'd0);
      end
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_grant_noval", 32'(out_valid), 32'd0);
      chk("idle_grant_dst", 32'(port_dst), 32'd0);
    end
    grant = 1'b0;
    chk("drain_count", 32'(u_dut.u_fifo.count_q), 32'd0);
    chk("drain_in_ready", 32'(in_ready), 32'd1);

    // asynchronous reset mid-REQ with 3 flits buffered
    do_reset();
    for (int i = 0; i < 3; i++) push(g[i]);
    chk("pre_rst_dst", 32'(port_dst), 32'(gr[0]));
    chk("pre_rst_count", 32'(u_dut.u_fifo.count_q), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_count", 32'(u_dut.u_fifo.count_q), 32'd0);
    chk("mid_rst_dst", 32'(port_dst), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    tick();
    tick();
    chk("post_rst_dst", 32'(port_dst), 32'd0);
    chk("post_rst_count", 32'(u_dut.u_fifo.count_q), 32'd0);

    // full FIFO: pop frees a slot, then push and pop in the same cycle
    h[0] = 16'h0101; h[1] = 16'hE202; h[2] = 16'h6303; h[3] = 16'h4404; h[4] = 16'h0505;
    do_reset();
    for (int i = 0; i < 4; i++) push(h[i]);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    grant = 1'b1;
    tick();
    grant = 1'b0;
    chk("pp_out0", 32'(out_flit), 32'(h[0]));
    chk("pp_count3", 32'(u_dut.u_fifo.count_q), 32'd3);
    chk("pp_in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("pp_req_dst", 32'(port_dst), 32'd3);
    grant    = 1'b1;
    in_valid = 1'b1;
    in_flit  = h[4];
    tick();
    in_valid = 1'b0;
    chk("pp_count_same", 32'(u_dut.u_fifo.count_q), 32'd3);
    chk("pp_out1_valid", 32'(out_valid), 32'd1);
    chk("pp_out1", 32'(out_flit), 32'(h[1]));
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i % 2 == 1) begin
        chk("pp_drain_valid", 32'(out_valid), 32'd1);
        chk("pp_drain_flit", 32'(out_flit), 32'(h[2 + i/2]));
      end else begin
        chk("pp_drain_noval", 32'(out_valid), 32'd0);
      end
    end
    grant = 1'b0;
    tick();
    chk("pp_end_count", 32'(u_dut.u_fifo.count_q), 32'd0);
    chk("pp_end_dst", 32'(port_dst), 32'd0);

`ifdef IN_UNIT_CREDIT_EN
    tick();
    chk("credit_vs_valid", 32'(n_cr), 32'(n_ov));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
